// File: rtl/sym_seq_gen.sv
// rtl/sym_seq_gen.sv - programmable (symbol, hold) table player feeding the 2-bit detector x input
// Optional looping playback is compiled in with `define SYMGEN_LOOP_EN.
module sym_seq_gen #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [1:0]               load_sym,
    input  logic [HOLD_W-1:0]        load_hold,
    input  logic [$clog2(DEPTH)-1:0] last,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     loop,
    output logic [1:0]               x,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] idx
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sym_q  [DEPTH];
    logic [HOLD_W-1:0]   hold_q [DEPTH];
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [AW-1:0]       last_q, last_d;
    logic [AW-1:0]       idx_inc;
    logic [1:0]          x_q, x_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wrap;

`ifdef SYMGEN_LOOP_EN
    assign wrap = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign wrap        = 1'b0;
`endif

    assign idx_inc = idx_q + AW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            x_q     <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                sym_q[i]  <= 2'b00;
                hold_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            // The table is only writable while idle and not being started.
            if (load && state_q == ST_IDLE && !start) begin
                sym_q[load_addr]  <= load_sym;
                hold_q[load_addr] <= load_hold;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_EMIT;
            ST_EMIT: begin
                if (abort)
                    state_d = ST_IDLE;
                else if (cnt_q == '0 && idx_q == last_q && !wrap)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d  = '0;
                    last_d = last;
                    cnt_d  = hold_q[0];
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    idx_d = '0;
                    cnt_d = '0;
                end else if (cnt_q == '0) begin
                    if (idx_q < last_q) begin
                        idx_d = idx_inc;
                        cnt_d = hold_q[idx_inc];
                    end else if (wrap) begin
                        idx_d = '0;
                        cnt_d = hold_q[0];
                    end
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: ;
        endcase
        // Outputs are registered from the upcoming state so x lines up with idx.
        x_d    = (state_d == ST_EMIT) ? sym_q[idx_d] : 2'b00;
        busy_d = (state_d == ST_EMIT);
        done_d = (state_d == ST_DONE);
    end

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;
    assign idx  = idx_q;

endmodule

// File: tb/tb_sym_seq_gen.sv
// tb/tb_sym_seq_gen.sv - directed self-checking bench for sym_seq_gen
module tb_sym_seq_gen;

    logic       clk = 1'b0;
    logic       reset, load, start, abort, loop;
    logic [2:0] load_addr, last, idx;
    logic [1:0] load_sym, x;
    logic [3:0] load_hold;
    logic       busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    sym_seq_gen #(.DEPTH(8), .HOLD_W(4)) dut (
        .clk(clk), .reset(reset), .load(load), .load_addr(load_addr),
        .load_sym(load_sym), .load_hold(load_hold), .last(last),
        .start(start), .abort(abort), .loop(loop),
        .x(x), .busy(busy), .done(done), .idx(idx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input int s, input int h);
        load      = 1'b1;
        load_addr = 3'(a);
        load_sym  = 2'(s);
        load_hold = 4'(h);
        tick();
        load      = 1'b0;
    endtask

    task automatic check_out(input string tag, input int ex, input int eb, input int ed, input int ei);
        check_eq({tag, ".x"},    int'(x),    ex);
        check_eq({tag, ".busy"}, int'(busy), eb);
        check_eq({tag, ".done"}, int'(done), ed);
        check_eq({tag, ".idx"},  int'(idx),  ei);
    endtask

    task automatic pulse_start(input int l);
        last  = 3'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 0; start = 1'b1; abort = 0; loop = 0;
        load_addr = 0; load_sym = 0; load_hold = 0; last = 0;

        for (int c = 0; c < 3; c++) begin
            tick();
            check_out("reset", 0, 0, 0, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        check_out("idle", 0, 0, 0, 0);

        // Basic playback, with a load/start attempted mid-run that must be ignored
        write_entry(0, 3, 9);
        write_entry(1, 2, 9);
        write_entry(2, 0, 9);
        pulse_start(2);
        for (int c = 1; c <= 30; c++) begin
            check_out("basic", (c <= 10) ? 3 : (c <= 20) ? 2 : 0, 1, 0, (c - 1) / 10);
            if (c == 15) begin
                load = 1'b1; load_addr = 3'd2; load_sym = 2'd1; load_hold = 4'd0;
                start = 1'b1;
            end else begin
                load  = 1'b0;
                start = 1'b0;
            end
            tick();
        end
        check_out("basic_done", 0, 0, 1, 2);
        tick();
        check_out("basic_after", 0, 0, 0, 2);

        // Minimum dwell
        write_entry(0, 1, 0);
        write_entry(1, 2, 0);
        write_entry(2, 3, 0);
        write_entry(3, 0, 0);
        pulse_start(3);
        check_out("min1", 1, 1, 0, 0);
        tick();
        check_out("min2", 2, 1, 0, 1);
        tick();
        check_out("min3", 3, 1, 0, 2);
        tick();
        check_out("min4", 0, 1, 0, 3);
        tick();
        check_out("min_done", 0, 0, 1, 3);
        tick();

        // Abort 4 cycles into entry 0
        write_entry(0, 3, 9);
        pulse_start(2);
        for (int c = 1; c <= 4; c++) begin
            check_out("pre_abort", 3, 1, 0, 0);
            if (c < 4) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("abort", 0, 0, 0, 0);
        for (int c = 0; c < 12; c++) begin
            tick();
            check_eq("abort_no_done", int'(done), 0);
        end

        // Reset during entry 1, then replay from a cleared table
        write_entry(0, 3, 1);
        write_entry(1, 2, 5);
        pulse_start(1);
        check_out("rst_e0", 3, 1, 0, 0);
        tick();
        tick();
        check_out("rst_e1", 2, 1, 0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_out("mid_reset", 0, 0, 0, 0);
        pulse_start(2);
        for (int c = 1; c <= 3; c++) begin
            check_out("cleared", 0, 1, 0, c - 1);
            tick();
        end
        check_out("cleared_done", 0, 0, 1, 2);
        tick();

        // Loop input: repeats when compiled in, ignored otherwise
        write_entry(0, 1, 1);
        write_entry(1, 2, 1);
        loop = 1'b1;
        pulse_start(1);
`ifdef SYMGEN_LOOP_EN
        for (int c = 1; c <= 12; c++) begin
            check_out("loop", ((c - 1) % 4 < 2) ? 1 : 2, 1, 0, ((c - 1) % 4) / 2);
            if (c == 10) loop = 1'b0;
            tick();
        end
        check_out("loop_end", 0, 0, 1, 1);
        tick();
        check_out("loop_idle", 0, 0, 0, 1);
`else
        for (int c = 1; c <= 4; c++) begin
            check_out("noloop", (c < 3) ? 1 : 2, 1, 0, (c - 1) / 2);
            tick();
        end
        check_out("noloop_done", 0, 0, 1, 1);
        tick();
        check_out("noloop_idle", 0, 0, 0, 1);
`endif
        loop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
